// File: rtl/lcd_stream_capture.sv
// Pixelstream LCD capture: samples RGB/sync/DE on pix_en, frame-aligns it and
// emits an Avalon-ST pixel stream with sop/eop through a show-ahead FIFO.
module lcd_stream_capture #(
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 480,
    parameter int FIFO_DEPTH      = 16,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [7:0]  lcd_red,
    input  logic [7:0]  lcd_green,
    input  logic [7:0]  lcd_blue,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_de,
    output logic [23:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_sop,
    output logic        st_eop,
    input  logic        clear_status,
    output logic        overflow,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] frame_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE);

    typedef enum logic [1:0] {WAIT_VSYNC, ARMED, ACTIVE} state_t;

    // Stage 1: raw sample plus the previous sample's vsync/de, so edges span pix_en gaps
    logic        r_s1_vld;
    logic [23:0] r_s1_rgb;
    logic        r_s1_vs, r_s1_vs_prev, r_s1_de, r_s1_de_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld     <= 1'b0;
            r_s1_rgb     <= '0;
            r_s1_vs      <= SYNC_ACTIVE_LOW;
            r_s1_vs_prev <= SYNC_ACTIVE_LOW;
            r_s1_de      <= 1'b0;
            r_s1_de_prev <= 1'b0;
        end else begin
            r_s1_vld <= pix_en;
            if (pix_en) begin
                r_s1_rgb     <= {lcd_red, lcd_green, lcd_blue};
                r_s1_vs      <= lcd_vsync;
                r_s1_vs_prev <= r_s1_vs;
                r_s1_de      <= lcd_de;
                r_s1_de_prev <= r_s1_de;
            end
        end
    end

    logic w_vs_start, w_de_fall;
    assign w_vs_start = (r_s1_vs ^ SYNC_ACTIVE_LOW) & ~(r_s1_vs_prev ^ SYNC_ACTIVE_LOW);
    assign w_de_fall  = r_s1_de_prev & ~r_s1_de;

    // Stage 2: decoded events consumed by the framing FSM
    logic        r_s2_vld, r_s2_vs_start, r_s2_de_fall, r_s2_de;
    logic [23:0] r_s2_rgb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_vld      <= 1'b0;
            r_s2_vs_start <= 1'b0;
            r_s2_de_fall  <= 1'b0;
            r_s2_de       <= 1'b0;
            r_s2_rgb      <= '0;
        end else begin
            r_s2_vld      <= r_s1_vld;
            r_s2_vs_start <= r_s1_vld & w_vs_start;
            r_s2_de_fall  <= r_s1_vld & w_de_fall;
            r_s2_de       <= r_s1_vld & r_s1_de;
            r_s2_rgb      <= r_s1_rgb;
        end
    end

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
    logic [25:0]   r_mem [FIFO_DEPTH];
    logic          r_overflow, r_line_err, r_frame_err;
    logic [15:0]   r_frame_count;

    logic w_empty, w_full, w_pop;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = ~w_empty & st_ready;

    logic          w_push, w_sop, w_eop, w_drop, w_long, w_short;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;

    always_comb begin
        w_push  = 1'b0;
        w_sop   = 1'b0;
        w_long  = 1'b0;
        w_short = 1'b0;
        w_x     = (r_state == ARMED) ? '0 : r_x;
        w_y     = (r_state == ARMED) ? '0 : r_y;
        if (r_s2_vld) begin
            if (r_state == ARMED) begin
                w_push = r_s2_de;
                w_sop  = 1'b1;
            end else if (r_state == ACTIVE) begin
                if (r_s2_vs_start)   w_short = 1'b1;
                else if (r_s2_de) begin
                    if (r_x < X_MAX) w_push = 1'b1;
                    else             w_long = 1'b1;
                end
            end
        end
        w_eop  = (w_x == X_LAST) && (w_y == Y_LAST);
        w_drop = w_push & w_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= WAIT_VSYNC;
            r_x           <= '0;
            r_y           <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_overflow    <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push) begin
                // a dropped pixel abandons the rest of the frame
                if (w_full) r_state <= WAIT_VSYNC;
                else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_x      <= w_x + 1'b1;
                    r_y      <= w_y;
                    if (w_eop) begin
                        r_frame_count <= r_frame_count + 1'b1;
                        r_state       <= WAIT_VSYNC;
                    end else begin
                        r_state <= ACTIVE;
                    end
                end
            end else if (r_s2_vld) begin
                case (r_state)
                    WAIT_VSYNC: if (r_s2_vs_start) r_state <= ARMED;
                    ARMED: begin
                        r_x <= '0;
                        r_y <= '0;
                    end
                    ACTIVE: begin
                        if (r_s2_vs_start) begin
                            r_state <= ARMED;
                            r_x     <= '0;
                            r_y     <= '0;
                        end else if (r_s2_de_fall) begin
                            r_x <= '0;
                            if (r_y < Y_MAX) r_y <= r_y + 1'b1;
                        end
                    end
                    default: r_state <= WAIT_VSYNC;
                endcase
            end
            r_overflow  <= w_drop  | (r_overflow  & ~clear_status);
            r_line_err  <= w_long  | (r_line_err  & ~clear_status);
            r_frame_err <= w_short | (r_frame_err & ~clear_status);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push && !w_full) r_mem[r_wr_ptr[AW-1:0]] <= {w_sop, w_eop, r_s2_rgb};
    end

    logic [25:0] w_head;
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign {st_sop, st_eop, st_data} = w_head;
    assign st_valid    = ~w_empty;
    assign overflow    = r_overflow;
    assign line_err    = r_line_err;
    assign frame_err   = r_frame_err;
    assign frame_count = r_frame_count;

    logic w_unused;
    assign w_unused = lcd_hsync;
endmodule

// File: tb/tb_lcd_stream_capture.sv
// Directed bench for lcd_stream_capture: a queue-based model of the framing rules
// checked every cycle, plus literal expectations per scenario.
module tb_lcd_stream_capture;
    localparam int H = 4, V = 2, D = 4;

    logic clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
    logic [7:0] lcd_red = '0, lcd_green = '0, lcd_blue = '0;
    logic lcd_hsync = 1'b1, lcd_vsync = 1'b1, lcd_de = 1'b0;
    logic st_ready = 1'b1, clear_status = 1'b0;
    logic [23:0] st_data;
    logic st_valid, st_sop, st_eop, overflow, line_err, frame_err;
    logic [15:0] frame_count;

    lcd_stream_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .lcd_red(lcd_red), .lcd_green(lcd_green), .lcd_blue(lcd_blue),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop), .clear_status(clear_status),
        .overflow(overflow), .line_err(line_err), .frame_err(frame_err),
        .frame_count(frame_count));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int gap = 1;
    bit mon_on = 0, lat_arm = 0, lat_watch = 0;
    time t_drive = 0, t_valid = 0;
    logic [25:0] got[$], xq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [25:0] bt(input bit s, input bit e, input logic [23:0] d);
        return {s, e, d};
    endfunction

    // Model: FIFO is a queue; each pixel sample takes effect two edges after it is taken
    logic [25:0] mq[$];
    int m_st = 0, mx = 0, my = 0;   // 0 waiting for vsync, 1 armed, 2 in frame
    bit m_ovf = 0, m_le = 0, m_fe = 0, m_pvs = 0, m_pde = 0;
    logic [15:0] m_fc = '0;
    bit e_v[2], e_vs[2], e_df[2], e_de[2];
    logic [23:0] e_d[2];

    task automatic model_edge();
        int sz;
        bit do_pop, so, sl, sf, want, sopb, eopb, pushed, vs_act;
        logic [25:0] nb;
        if (!reset && st_valid && st_ready) got.push_back({st_sop, st_eop, st_data});
        if (reset) begin
            mq.delete();
            m_st = 0; mx = 0; my = 0; m_ovf = 0; m_le = 0; m_fe = 0; m_fc = '0;
            m_pvs = 0; m_pde = 0; e_v[0] = 0; e_v[1] = 0;
            return;
        end
        sz = mq.size();
        do_pop = st_ready && (sz > 0);
        so = 0; sl = 0; sf = 0; want = 0; sopb = 0; eopb = 0; pushed = 0; nb = '0;
        if (e_v[1]) begin
            case (m_st)
                0: if (e_vs[1]) m_st = 1;
                1: begin mx = 0; my = 0; if (e_de[1]) begin want = 1; sopb = 1; end end
                default: begin
                    if (e_vs[1]) begin sf = 1; m_st = 1; mx = 0; my = 0; end
                    else if (e_de[1]) begin if (mx < H) want = 1; else sl = 1; end
                    else if (e_df[1]) begin mx = 0; my++; end
                end
            endcase
            if (want) begin
                if (sz == D) begin so = 1; m_st = 0; end
                else begin
                    eopb = (mx == H - 1) && (my == V - 1);
                    nb = bt(sopb, eopb, e_d[1]);
                    pushed = 1;
                    mx++;
                    m_st = eopb ? 0 : 2;
                    if (eopb) m_fc++;
                end
            end
        end
        if (do_pop) mq.delete(0);
        if (pushed) mq.push_back(nb);
        m_ovf = so || (m_ovf && !clear_status);
        m_le  = sl || (m_le && !clear_status);
        m_fe  = sf || (m_fe && !clear_status);
        e_v[1] = e_v[0]; e_vs[1] = e_vs[0]; e_df[1] = e_df[0]; e_de[1] = e_de[0]; e_d[1] = e_d[0];
        e_v[0] = pix_en;
        if (pix_en) begin
            vs_act = !lcd_vsync;
            e_vs[0] = vs_act && !m_pvs;
            e_df[0] = m_pde && !lcd_de;
            e_de[0] = lcd_de;
            e_d[0]  = {lcd_red, lcd_green, lcd_blue};
            m_pvs = vs_act;
            m_pde = lcd_de;
        end
    endtask

    task automatic mon_edge();
        if (lat_watch && st_valid) begin t_valid = $time; lat_watch = 0; end
        if (!mon_on) return;
        chk("st_valid", 32'(st_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("beat", 32'({st_sop, st_eop, st_data}), 32'(mq[0]));
        chk("status", 32'({overflow, line_err, frame_err, frame_count}), 32'({m_ovf, m_le, m_fe, m_fc}));
    endtask

    always @(posedge clk) model_edge();
    always @(negedge clk) mon_edge();

    task automatic step(input bit vs, input bit de, input logic [23:0] d);
        @(negedge clk);
        pix_en = 1'b1; lcd_vsync = vs; lcd_de = de; {lcd_red, lcd_green, lcd_blue} = d;
        if (lat_arm && de) begin t_drive = $time; lat_arm = 0; end
        for (int i = 1; i < gap; i++) begin @(negedge clk); pix_en = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); pix_en = 1'b0; end
    endtask

    task automatic vsync_pulse();
        step(1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 24'h0);
    endtask

    task automatic line(input int n, input logic [23:0] base);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, base + 24'(i));
        step(1'b1, 1'b0, 24'h0);
    endtask

    task automatic frame(input logic [23:0] base);
        vsync_pulse();
        line(H, base);
        line(H, base + 24'(H));
    endtask

    task automatic exp_frame(input logic [23:0] base);
        for (int i = 0; i < H * V; i++) xq.push_back(bt(i == 0, i == H * V - 1, base + 24'(i)));
    endtask

    task automatic check_beats(input string nm);
        chk({nm, "_count"}, 32'(got.size()), 32'(xq.size()));
        for (int i = 0; i < xq.size() && i < got.size(); i++) chk(nm, 32'(got[i]), 32'(xq[i]));
        got.delete();
        xq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        mon_on = 1;
        chk("rst_valid", 32'(st_valid), 0);
        chk("rst_data", 32'({st_sop, st_eop, st_data}), 0);
        chk("rst_flags", 32'({overflow, line_err, frame_err}), 0);
        chk("rst_fc", 32'(frame_count), 0);
        reset = 1'b0;

        // Clean frame with first-beat latency
        lat_arm = 1; lat_watch = 1;
        frame(24'h1); idle(12);
        chk("latency", 32'(t_valid - t_drive), 30);
        exp_frame(24'h1); check_beats("clean");
        chk("clean_fc", 32'(frame_count), 1);
        chk("clean_flags", 32'({overflow, line_err, frame_err}), 0);

        // Backpressure: sparse pix_en, stall on beat 2
        gap = 4;
        fork
            frame(24'h1);
            begin
                bit found;
                found = 0;
                for (int k = 0; k < 300 && !found; k++) begin
                    @(negedge clk);
                    if (st_valid && st_data == 24'h2) found = 1;
                end
                chk("bp_found", 32'(found), 1);
                if (found) begin
                    st_ready = 1'b0;
                    repeat (3) begin @(negedge clk); chk("bp_hold", 32'({st_valid, st_data}), 32'({1'b1, 24'h2})); end
                    st_ready = 1'b1;
                end
            end
        join
        gap = 1;
        idle(30);
        exp_frame(24'h1); check_beats("bp");
        chk("bp_ovf", 32'(overflow), 0);
        chk("bp_fc", 32'(frame_count), 2);

        // Overflow with the sink stalled for the whole frame
        st_ready = 1'b0;
        frame(24'h1); idle(4);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_none_out", 32'(got.size()), 0);
        chk("ovf_fc", 32'(frame_count), 2);
        st_ready = 1'b1; idle(8);
        for (int i = 1; i <= 4; i++) xq.push_back(bt(i == 1, 1'b0, 24'(i)));
        check_beats("ovf");
        frame(24'h31); idle(12);
        exp_frame(24'h31); check_beats("ovf_next");
        chk("ovf_next_fc", 32'(frame_count), 3);

        @(negedge clk); clear_status = 1'b1;
        @(negedge clk); clear_status = 1'b0;
        chk("clear", 32'(overflow), 0);

        // clear_status on the very edge the drop happens
        st_ready = 1'b0;
        vsync_pulse(); line(H, 24'h1);
        step(1'b1, 1'b1, 24'h5);
        step(1'b1, 1'b1, 24'h6);
        step(1'b1, 1'b1, 24'h7);
        clear_status = 1'b1;
        step(1'b1, 1'b1, 24'h8);
        clear_status = 1'b0;
        step(1'b1, 1'b0, 24'h0); idle(3);
        chk("clr_vs_ovf", 32'(overflow), 1);
        st_ready = 1'b1; idle(8);
        for (int i = 1; i <= 4; i++) xq.push_back(bt(i == 1, 1'b0, 24'(i)));
        check_beats("clr_ovf");

        // Long line: pixels 5,6 of line 0 dropped
        vsync_pulse(); line(6, 24'h1); line(H, 24'h7); idle(12);
        for (int i = 1; i <= 4; i++) xq.push_back(bt(i == 1, 1'b0, 24'(i)));
        for (int i = 7; i <= 10; i++) xq.push_back(bt(1'b0, i == 10, 24'(i)));
        check_beats("long");
        chk("long_err", 32'(line_err), 1);
        chk("long_fc", 32'(frame_count), 4);

        // Short frame then a full one
        vsync_pulse(); line(H, 24'h1); frame(24'h11); idle(12);
        for (int i = 1; i <= 4; i++) xq.push_back(bt(i == 1, 1'b0, 24'(i)));
        exp_frame(24'h11); check_beats("short");
        chk("short_err", 32'(frame_err), 1);
        chk("short_fc", 32'(frame_count), 5);

        // Reset mid-frame with three beats buffered
        st_ready = 1'b0;
        vsync_pulse();
        step(1'b1, 1'b1, 24'h1); step(1'b1, 1'b1, 24'h2); step(1'b1, 1'b1, 24'h3);
        idle(4);
        chk("pre_rst_flags", 32'({overflow, line_err, frame_err}), 32'h7);
        chk("pre_rst_valid", 32'(st_valid), 1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_valid", 32'(st_valid), 0);
        chk("mid_rst_flags", 32'({overflow, line_err, frame_err}), 0);
        chk("mid_rst_fc", 32'(frame_count), 0);
        st_ready = 1'b1;
        line(H, 24'h21); idle(8);
        chk("rst_ignored", 32'(got.size()), 0);
        frame(24'h41); idle(12);
        exp_frame(24'h41); check_beats("after_rst");
        chk("after_rst_fc", 32'(frame_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
